// File: rtl/gbus_req_node_if.sv
// rtl/gbus_req_node_if.sv - gbus requester handshake bundle: local beat input, arbiter req/grant, gbus drive
interface gbus_req_node_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  req;
  logic                  grant;
  logic                  bus_valid;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_data;

  modport master (
    input  in_valid, in_addr, in_data, grant,
    output in_ready, req, bus_valid, bus_addr, bus_data
  );

  modport slave (
    output in_valid, in_addr, in_data, grant,
    input  in_ready, req, bus_valid, bus_addr, bus_data
  );
endinterface

// File: rtl/gbus_req_node.sv
// rtl/gbus_req_node.sv - gbus requester node: beat FIFO, req FSM, one-cycle grant-to-bus drive
// Optional starvation detector enabled by defining GBUS_REQ_TIMEOUT_EN.
module gbus_req_node #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  gbus_req_node_if.master bus,
  output logic [15:0]   sent_cnt,
  output logic          starve_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                state;
  logic                  req_q;
  logic                  bus_valid_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_data_q;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [EW-1:0]         head;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  push;
  logic                  pop;

  // in_ready looks only at the stored count so a full FIFO never accepts on a popping edge
  assign bus.in_ready = (count != CW'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = req_q && bus.grant;
  assign count_nxt    = count + CW'(push) - CW'(pop);
  assign head         = mem[rd_ptr];

  assign bus.req       = req_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_data  = bus_data_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_addr, bus.in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      sent_cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nxt;

      case (state)
        S_IDLE: begin
          if (count_nxt != '0) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (pop && !push && count == CW'(1)) begin
            state <= S_IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase

      // Bus registers hold zero whenever no beat is being driven
      if (pop) begin
        bus_valid_q <= 1'b1;
        bus_addr_q  <= head[EW-1:DATA_WIDTH];
        bus_data_q  <= head[DATA_WIDTH-1:0];
        sent_cnt    <= sent_cnt + 16'd1;
      end else begin
        bus_valid_q <= 1'b0;
        bus_addr_q  <= '0;
        bus_data_q  <= '0;
      end
    end
  end

`ifdef GBUS_REQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      starve_err <= 1'b0;
    end else if (req_q && !bus.grant) begin
      if (wait_cnt != WW'(TIMEOUT_CYC)) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
      if (wait_cnt >= WW'(TIMEOUT_CYC - 1)) begin
        starve_err <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign starve_err = 1'b0;
`endif
endmodule
